regfile_banked: RTL

- Parametrised successor to the CPU register file.
- Holds NUM_PAIRS 16-bit register pairs with per-byte write enables and NUM_RD independent read ports.
- Includes a flag register with per-bit write mask and an integrated increment/decrement unit (IDU) for HL+/HL-, SP and PC updates.
- Sits between decode/ALU and the memory address path.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_banked_idu16.sv | 12 +
 rtl/regfile_banked.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the banked register file: pair indices, flag bit
// positions and the address-width helper.
package regfile_pkg;

    localparam int IDX_BC = 0;
    localparam int IDX_DE = 1;
    localparam int IDX_HL = 2;
    localparam int IDX_SP = 3;
    localparam int IDX_PC = 4;
    localparam int IDX_A  = 5;

    localparam int NUM_PAIRS_DEF = 6;

    // Keep at least one index bit even for a single-pair configuration.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW = addr_w(NUM_PAIRS_DEF);

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

endpackage

// File: rtl/regfile_banked_idu16.sv
// Increment/decrement unit: combinational +/-1 that wraps modulo 2^W.
module idu16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic         dec,
    output logic [W-1:0] y
);

    assign y = dec ? (a - W'(1)) : (a + W'(1));

endmodule

// File: rtl/regfile_banked.sv
// Register file of 16-bit pairs with byte write enables, multiple read ports,
// optional write-to-read bypass, masked flag register and an IDU.
module regfile_banked
    import regfile_pkg::*;
#(
    parameter int                      BYTE_W         = 8,
    parameter int                      NUM_PAIRS      = 6,
    parameter int                      NUM_RD         = 2,
    parameter int                      BYPASS         = 1,
    parameter int                      SP_IDX         = IDX_SP,
    parameter logic [2*BYTE_W-1:0]     SP_RESET       = 16'hFFFE,
    parameter logic [BYTE_W-1:0]       FLAG_ZERO_MASK = 8'h0F,
    localparam int                     RAW            = addr_w(NUM_PAIRS),
    localparam int                     PW             = 2*BYTE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              wr_en,
    input  logic [RAW-1:0]          wr_reg,
    input  logic [PW-1:0]           wr_data,
    input  logic [NUM_RD*RAW-1:0]   rd_reg,
    output logic [NUM_RD*PW-1:0]    rd_data,
    input  logic                    flag_we,
    input  logic [BYTE_W-1:0]       flag_mask,
    input  logic [BYTE_W-1:0]       flag_data,
    output logic [BYTE_W-1:0]       rd_flag,
    input  logic                    idu_en,
    input  logic                    idu_dec,
    input  logic [RAW-1:0]          idu_reg,
    output logic [PW-1:0]           idu_old
);

    logic [PW-1:0]     pair_q [NUM_PAIRS];
    logic [PW-1:0]     pair_d [NUM_PAIRS];
    logic [BYTE_W-1:0] flag_q;
    logic [BYTE_W-1:0] flag_d;
    logic [PW-1:0]     idu_new;
    logic              wr_hit;
    logic [RAW-1:0]    rd_idx;
    logic [PW-1:0]     rd_val;

    assign wr_hit = (|wr_en) && (int'(wr_reg) < NUM_PAIRS);

    always_comb begin
        idu_old = '0;
        if (int'(idu_reg) < NUM_PAIRS) idu_old = pair_q[idu_reg];
    end

    idu16 #(.W(PW)) u_idu (
        .a   (idu_old),
        .dec (idu_dec),
        .y   (idu_new)
    );

    // IDU result lands first so that enabled port-write bytes override it.
    always_comb begin
        for (int i = 0; i < NUM_PAIRS; i++) begin
            pair_d[i] = pair_q[i];
            if (idu_en && idu_reg == RAW'(i)) pair_d[i] = idu_new;
            if (wr_reg == RAW'(i)) begin
                if (wr_en[1]) pair_d[i][PW-1:BYTE_W] = wr_data[PW-1:BYTE_W];
                if (wr_en[0]) pair_d[i][BYTE_W-1:0]  = wr_data[BYTE_W-1:0];
            end
        end
    end

    always_comb begin
        flag_d = flag_q;
        if (flag_we) flag_d = (flag_q & ~flag_mask) | (flag_data & flag_mask);
        flag_d = flag_d & ~FLAG_ZERO_MASK;
    end

    assign rd_flag = flag_q;

    // Bypass forwards only port-write bytes, never the IDU result.
    always_comb begin
        rd_data = '0;
        rd_idx  = '0;
        rd_val  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_idx = rd_reg[k*RAW +: RAW];
            rd_val = '0;
            if (int'(rd_idx) < NUM_PAIRS) rd_val = pair_q[rd_idx];
            if (BYPASS != 0 && wr_hit && rd_idx == wr_reg) begin
                if (wr_en[1]) rd_val[PW-1:BYTE_W] = wr_data[PW-1:BYTE_W];
                if (wr_en[0]) rd_val[BYTE_W-1:0]  = wr_data[BYTE_W-1:0];
            end
            rd_data[k*PW +: PW] = rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                pair_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            flag_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                pair_q[i] <= pair_d[i];
            end
            flag_q <= flag_d;
        end
    end

endmodule
